// File: rtl/note_section_player.sv
// note_section_player: plays a writable DEPTH x LANES note chart one step per beat_tick with looping, pause and stop
module note_section_player #(
  parameter int LANES = 5,
  parameter int AW    = 6,
  parameter int DEPTH = 2**AW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             beat_tick,
  input  logic [AW-1:0]    sec_len,
  input  logic [3:0]       loop_count,
  output logic [LANES-1:0] exp_notes,
  output logic [AW-1:0]    step,
  output logic             busy,
  output logic             note_strobe,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSED} state_t;

  state_t           st, st_n;
  logic [LANES-1:0] mem [DEPTH];
  logic [AW-1:0]    last, last_n, step_n;
  logic [3:0]       loops, loops_n;
  logic             ld, clr, done_n;

  // Chart write port; no reset so it maps onto plain RAM
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  // Next-state and step control; stop beats start beats beat_tick, pause only gates the tick
  always_comb begin
    st_n    = st;
    step_n  = step;
    last_n  = last;
    loops_n = loops;
    ld      = 1'b0;
    clr     = 1'b0;
    done_n  = 1'b0;
    if (stop) begin
      st_n   = IDLE;
      step_n = '0;
      clr    = 1'b1;
    end else if (start) begin
      st_n    = PLAY;
      last_n  = sec_len;
      loops_n = loop_count;
      step_n  = '0;
      ld      = 1'b1;
    end else if (st == PLAY && pause) begin
      st_n = PAUSED;
    end else if (st == PAUSED && !pause) begin
      st_n = PLAY;
    end else if (st == PLAY && beat_tick) begin
      if (step != last) begin
        step_n = step + 1'b1;
        ld     = 1'b1;
      end else if (loops == 4'd1) begin
        st_n   = IDLE;
        step_n = '0;
        clr    = 1'b1;
        done_n = 1'b1;
      end else begin
        step_n  = '0;
        ld      = 1'b1;
        loops_n = (loops == 4'd0) ? loops : loops - 4'd1;
      end
    end
  end

  // State, latched section parameters and outputs; the read address is the next step so
  // the RAM read lands in exp_notes on the same edge that accepts the event (read-first)
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st          <= IDLE;
      step        <= '0;
      last        <= '0;
      loops       <= '0;
      exp_notes   <= '0;
      note_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      st          <= st_n;
      step        <= step_n;
      last        <= last_n;
      loops       <= loops_n;
      exp_notes   <= clr ? '0 : ld ? mem[step_n] : exp_notes;
      note_strobe <= ld && (mem[step_n] != '0);
      done        <= done_n;
    end

  assign busy = (st != IDLE);
endmodule

// File: tb/tb_note_section_player.sv
// tb_note_section_player: scoreboard bench for note_section_player with directed chart playback vectors
module tb_note_section_player;
  logic       clk = 1'b0, resetn = 1'b0;
  logic       wr_en = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, beat_tick = 1'b0;
  logic [5:0] wr_addr = '0, sec_len = '0;
  logic [4:0] wr_data = '0;
  logic [3:0] loop_count = '0;
  logic [4:0] exp_notes;
  logic [5:0] step;
  logic       busy, note_strobe, done;

  typedef struct {string nm; logic [13:0] v;} exp_t;
  exp_t       sb[$];
  exp_t       e;
  int         total = 0, passed = 0;
  logic [4:0] c [4];

  note_section_player dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .pause(pause), .beat_tick(beat_tick),
    .sec_len(sec_len), .loop_count(loop_count), .exp_notes(exp_notes), .step(step),
    .busy(busy), .note_strobe(note_strobe), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [13:0] act, logic [13:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got notes=%b step=%0d busy=%b strobe=%b done=%b, expected notes=%b step=%0d busy=%b strobe=%b done=%b",
                  nm, act[13:9], act[8:3], act[2], act[1], act[0], exp[13:9], exp[8:3], exp[2], exp[1], exp[0]);
  endfunction

  // Monitor: outputs are registered, so compare each expected entry half a cycle after its edge
  always @(negedge clk)
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.nm, {exp_notes, step, busy, note_strobe, done}, e.v);
    end

  task automatic cyc(string nm, logic st, sp, pa, bt, logic [4:0] en, logic [5:0] es, logic eb, ss, ed);
    @(negedge clk);
    start = st; stop = sp; pause = pa; beat_tick = bt;
    @(posedge clk);
    sb.push_back('{nm, {en, es, eb, ss, ed}});
    #1 wr_en = 1'b0;
  endtask

  task automatic wr(logic [5:0] a, logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc("write", 0, 0, 0, 0, 5'b0, 6'd0, 0, 0, 0);
  endtask

  initial begin
    c[0] = 5'b10101; c[1] = 5'b01110; c[2] = 5'b00000; c[3] = 5'b00001;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    cyc("reset_state", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) wr(6'(i), c[i]);

    // single pass
    sec_len = 6'd3; loop_count = 4'd1;
    cyc("p1_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    cyc("p1_t1", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);
    cyc("p1_t2", 0, 0, 0, 1, c[2], 6'd2, 1, 0, 0);
    cyc("p1_t3", 0, 0, 0, 1, c[3], 6'd3, 1, 1, 0);
    cyc("p1_done", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 1);
    cyc("p1_idle_tick", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 0);

    // two passes
    loop_count = 4'd2;
    cyc("p2_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    for (int k = 1; k < 8; k++)
      cyc("p2_tick", 0, 0, 0, 1, c[k%4], 6'(k%4), 1, c[k%4] != 0, 0);
    cyc("p2_done", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 1);

    // infinite loop, then stop
    loop_count = 4'd0;
    cyc("inf_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    for (int k = 1; k <= 20; k++)
      cyc("inf_tick", 0, 0, 0, 1, c[k%4], 6'(k%4), 1, c[k%4] != 0, 0);
    cyc("inf_stop", 0, 1, 0, 1, 5'b0, 6'd0, 0, 0, 0);

    // pause at step 1; release with coincident tick is ignored
    cyc("pz_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    cyc("pz_t1", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);
    for (int k = 0; k < 3; k++) cyc("pz_hold", 0, 0, 1, 1, c[1], 6'd1, 1, 0, 0);
    cyc("pz_release", 0, 0, 0, 1, c[1], 6'd1, 1, 0, 0);
    cyc("pz_next", 0, 0, 0, 1, c[2], 6'd2, 1, 0, 0);
    cyc("pz_stop", 0, 1, 0, 0, 5'b0, 6'd0, 0, 0, 0);

    // write to chart[2] in the same cycle it is read: old data first, new data next pass
    cyc("wc_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    cyc("wc_t1", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);
    wr_en = 1'b1; wr_addr = 6'd2; wr_data = 5'b11000;
    cyc("wc_old", 0, 0, 0, 1, c[2], 6'd2, 1, 0, 0);
    cyc("wc_t3", 0, 0, 0, 1, c[3], 6'd3, 1, 1, 0);
    cyc("wc_wrap", 0, 0, 0, 1, c[0], 6'd0, 1, 1, 0);
    cyc("wc_t5", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);
    cyc("wc_new", 0, 0, 0, 1, 5'b11000, 6'd2, 1, 1, 0);

    // restart mid-play with a shorter section, then stop beats start
    sec_len = 6'd1; loop_count = 4'd1;
    cyc("rs_start", 1, 0, 0, 1, c[0], 6'd0, 1, 1, 0);
    cyc("rs_t1", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);
    cyc("rs_done", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 1);
    cyc("stop_over_start", 1, 1, 0, 0, 5'b0, 6'd0, 0, 0, 0);

    // one-step section: every tick wraps, identical reload still strobes
    sec_len = 6'd0; loop_count = 4'd2;
    cyc("s0_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    cyc("s0_wrap", 0, 0, 0, 1, c[0], 6'd0, 1, 1, 0);
    cyc("s0_done", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 1);

    // asynchronous reset mid-playback at step 2
    sec_len = 6'd3; loop_count = 4'd0;
    cyc("ar_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    cyc("ar_t1", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);
    cyc("ar_t2", 0, 0, 0, 1, 5'b11000, 6'd2, 1, 1, 0);
    beat_tick = 1'b0;
    @(negedge clk);
    #1 resetn = 1'b0;
    #1 chk("async_reset", {exp_notes, step, busy, note_strobe, done}, 14'd0);
    @(negedge clk) resetn = 1'b1;
    cyc("post_reset_tick", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 0);
    cyc("post_reset_tick2", 0, 0, 0, 1, 5'b0, 6'd0, 0, 0, 0);
    cyc("post_reset_start", 1, 0, 0, 0, c[0], 6'd0, 1, 1, 0);
    cyc("post_reset_t1", 0, 0, 0, 1, c[1], 6'd1, 1, 1, 0);

    start = 1'b0; beat_tick = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
